// File: rtl/spi_burst_sequencer_if.sv
// ----------------------------------------------------------------------------
// spi_burst_sequencer_if
//   Groups every non-clock/reset signal of spi_burst_sequencer: the client
//   command/TX/RX handshakes, status flags and the register port of the
//   16-bit SPI master core.
//   Modports:
//     master - the sequencer itself (it masters the core register bus and
//              answers the client handshakes)
//     slave  - the environment: the client datapath plus the SPI core
//   Parameter LEN_W : width of cmd_len
// ----------------------------------------------------------------------------
interface spi_burst_sequencer_if #(
   parameter int LEN_W = 8
);
   // client command
   logic             cmd_valid;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_ready;
   // client TX stream
   logic [15:0]      tx_data;
   logic             tx_valid;
   logic             tx_ready;
   // client RX stream
   logic [15:0]      rx_data;
   logic             rx_valid;
   logic             rx_ready;
   // status
   logic             busy;
   logic             done;
   logic             error;
   // SPI core register port
   logic [2:0]       spi_mem_addr;
   logic [15:0]      spi_data_from_cpu;
   logic             spi_select;
   logic             spi_write_n;
   logic             spi_read_n;
   logic [15:0]      spi_data_to_cpu;
   logic             spi_readyfordata;
   logic             spi_dataavailable;

   modport master (
      input  cmd_valid, cmd_len, tx_data, tx_valid, rx_ready,
             spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
      output cmd_ready, tx_ready, rx_data, rx_valid, busy, done, error,
             spi_mem_addr, spi_data_from_cpu, spi_select, spi_write_n, spi_read_n
   );

   modport slave (
      output cmd_valid, cmd_len, tx_data, tx_valid, rx_ready,
             spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
      input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done, error,
             spi_mem_addr, spi_data_from_cpu, spi_select, spi_write_n, spi_read_n
   );
endinterface

// File: rtl/spi_burst_sequencer.sv
// ----------------------------------------------------------------------------
// spi_burst_sequencer
//   Drives the register port of the 16-bit SPI master core so that a burst of
//   cmd_len words goes out under one continuous SS_n assertion. One word is in
//   flight at a time: write TX, wait RRDY, read RX, hand it to the client.
//   Ports:
//     clk   - system clock, shared with the SPI core
//     reset - synchronous, active-high (core reset_n = ~reset)
//     bus   - spi_burst_sequencer_if.master: client cmd/TX/RX handshakes,
//             busy/done/error status, SPI core register port
//   Parameters:
//     LEN_W      - width of cmd_len
//     SLAVE_MASK - value written to the slave-enable register at burst start
//     RX_TIMEOUT - wait cycles for RRDY before the burst is aborted (>=64)
// ----------------------------------------------------------------------------
module spi_burst_sequencer #(
   parameter int          LEN_W      = 8,
   parameter logic [15:0] SLAVE_MASK = 16'h0001,
   parameter int          RX_TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_burst_sequencer_if.master bus
);

   localparam int TMR_W = ($clog2(RX_TIMEOUT + 1) > 10) ? $clog2(RX_TIMEOUT + 1) : 10;

   // core register map
   localparam logic [2:0] A_RXDATA  = 3'd0;
   localparam logic [2:0] A_TXDATA  = 3'd1;
   localparam logic [2:0] A_STATUS  = 3'd2;
   localparam logic [2:0] A_CONTROL = 3'd3;
   localparam logic [2:0] A_SLAVE   = 3'd5;
   localparam logic [15:0] CTRL_SSO = 16'h0400;

   typedef enum logic [3:0] {
      IDLE, CLR_STAT, SET_SLV, SSO_ON, WAIT_TX, WR_TX,
      WAIT_RX, RD_RX, RX_OUT, SSO_OFF, DONE
   } state_t;

   state_t           state, state_d;
   logic [1:0]       phase, phase_d;     // bus access: 0,1 = active, 2 = idle gap
   logic [LEN_W-1:0] count, count_d;     // words still to transfer
   logic [15:0]      tx_word, tx_word_d;
   logic [15:0]      rx_word, rx_word_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic             error_q, error_d;

   // per-state bus access description
   logic        acc_en;
   logic        acc_wr;
   logic [2:0]  acc_addr;
   logic [15:0] acc_data;
   state_t      acc_next;
   logic        acc_active;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         phase   <= '0;
         count   <= '0;
         tx_word <= '0;
         rx_word <= '0;
         timer   <= '0;
         error_q <= 1'b0;
      end else begin
         state   <= state_d;
         phase   <= phase_d;
         count   <= count_d;
         tx_word <= tx_word_d;
         rx_word <= rx_word_d;
         timer   <= timer_d;
         error_q <= error_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state;
      phase_d     = phase;
      count_d     = count;
      tx_word_d   = tx_word;
      rx_word_d   = rx_word;
      timer_d     = timer;
      error_d     = error_q;
      acc_en      = 1'b0;
      acc_wr      = 1'b1;
      acc_addr    = 3'd0;
      acc_data    = 16'h0000;
      acc_next    = state;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.done     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               count_d = bus.cmd_len;
               error_d = 1'b0;
               phase_d = '0;
               state_d = (bus.cmd_len == '0) ? DONE : CLR_STAT;
            end
         end
         CLR_STAT: begin
            acc_en = 1'b1; acc_addr = A_STATUS;  acc_data = 16'h0000;   acc_next = SET_SLV;
         end
         SET_SLV: begin
            acc_en = 1'b1; acc_addr = A_SLAVE;   acc_data = SLAVE_MASK; acc_next = SSO_ON;
         end
         SSO_ON: begin
            acc_en = 1'b1; acc_addr = A_CONTROL; acc_data = CTRL_SSO;   acc_next = WAIT_TX;
         end
         WAIT_TX: begin
            // SS_n stays asserted while the client stalls
            if (bus.tx_valid && bus.spi_readyfordata) begin
               bus.tx_ready = 1'b1;
               tx_word_d    = bus.tx_data;
               state_d      = WR_TX;
            end
         end
         WR_TX: begin
            acc_en = 1'b1; acc_addr = A_TXDATA;  acc_data = tx_word;    acc_next = WAIT_RX;
            timer_d = '0;
         end
         WAIT_RX: begin
            if (bus.spi_dataavailable) begin
               state_d = RD_RX;
            end else if (timer == TMR_W'(RX_TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = SSO_OFF;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         RD_RX: begin
            acc_en = 1'b1; acc_wr = 1'b0; acc_addr = A_RXDATA;        acc_next = RX_OUT;
            // read data is valid at the edge that ends the second access cycle
            if (phase == 2'd1) rx_word_d = bus.spi_data_to_cpu;
         end
         RX_OUT: begin
            bus.rx_valid = 1'b1;
            if (bus.rx_ready) begin
               count_d = count - 1'b1;
               state_d = (count == LEN_W'(1)) ? SSO_OFF : WAIT_TX;
            end
         end
         SSO_OFF: begin
            acc_en = 1'b1; acc_addr = A_CONTROL; acc_data = 16'h0000;   acc_next = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // shared access sequencing: two active cycles, one idle gap, then move on
      if (acc_en) begin
         if (phase == 2'd2) begin
            phase_d = '0;
            state_d = acc_next;
         end else begin
            phase_d = phase + 2'd1;
         end
      end
   end

   assign acc_active            = acc_en && (phase != 2'd2);
   assign bus.spi_select        = acc_active;
   assign bus.spi_write_n       = !(acc_active && acc_wr);
   assign bus.spi_read_n        = !(acc_active && !acc_wr);
   assign bus.spi_mem_addr      = acc_active ? acc_addr : 3'd0;
   assign bus.spi_data_from_cpu = acc_active ? acc_data : 16'h0000;

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.rx_data   = rx_word;
   assign bus.error     = error_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_burst_sequencer
//   Bench for spi_burst_sequencer with a behavioural SPI core whose MISO is
//   looped to MOSI (optionally with RRDY stuck low). Expected bus accesses and
//   RX words are queued when a burst is issued and compared with what the
//   bus monitor and the RX handshake observe.
// ----------------------------------------------------------------------------
module tb_spi_burst_sequencer;

   localparam int          LEN_W      = 8;
   localparam logic [15:0] SLAVE_MASK = 16'h0001;
   localparam int          RX_TIMEOUT = 1023;
   localparam int          BUDGET     = 4000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spi_burst_sequencer_if #(.LEN_W(LEN_W)) bus ();

   spi_burst_sequencer #(
      .LEN_W(LEN_W), .SLAVE_MASK(SLAVE_MASK), .RX_TIMEOUT(RX_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural SPI core ----------------
   logic [15:0] m_txbuf, m_rxreg, m_slave;
   logic        m_trdy, m_rrdy, m_roe, m_toe, m_sso;
   logic [1:0]  m_ph;
   int          m_shift;
   bit          stuck = 1'b0;

   assign bus.spi_readyfordata  = m_trdy;
   assign bus.spi_dataavailable = m_rrdy;
   assign bus.spi_data_to_cpu   = m_rxreg;

   always @(posedge clk) begin
      if (reset) begin
         m_txbuf <= '0; m_rxreg <= '0; m_slave <= '0;
         m_trdy <= 1'b1; m_rrdy <= 1'b0; m_roe <= 1'b0; m_toe <= 1'b0; m_sso <= 1'b0;
         m_ph <= '0; m_shift <= 0;
      end else begin
         m_ph <= bus.spi_select ? m_ph + 2'd1 : 2'd0;
         if (m_shift > 0) begin
            m_shift <= m_shift - 1;
            if (m_shift == 1) begin
               m_trdy <= 1'b1;
               if (!stuck) begin
                  m_rxreg <= m_txbuf;
                  m_rrdy  <= 1'b1;
                  if (m_rrdy) m_roe <= 1'b1;
               end
            end
         end
         if (bus.spi_select && m_ph == 2'd1) begin
            if (!bus.spi_write_n) begin
               case (bus.spi_mem_addr)
                  3'd1: begin
                     m_txbuf <= bus.spi_data_from_cpu;
                     m_shift <= 8;
                     m_trdy  <= 1'b0;
                     if (!m_trdy) m_toe <= 1'b1;
                  end
                  3'd2: begin m_roe <= 1'b0; m_toe <= 1'b0; m_rrdy <= 1'b0; end
                  3'd3: m_sso <= bus.spi_data_from_cpu[10];
                  3'd5: m_slave <= bus.spi_data_from_cpu;
                  default: ;
               endcase
            end else if (!bus.spi_read_n && bus.spi_mem_addr == 3'd0) begin
               m_rrdy <= 1'b0;
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] data;
      logic        wr;
   } acc_t;

   acc_t        obs_q[$];
   acc_t        exp_q[$];
   acc_t        cur;
   logic        cur_wn, cur_rn, prev_sel, prev_sso;
   int          run_len;
   int          viol = 0;
   int          sso_falls = 0;

   always @(negedge clk) begin
      prev_sso <= m_sso;
      if (!reset && prev_sso && !m_sso) sso_falls <= sso_falls + 1;
      if (reset) begin
         prev_sel <= 1'b0;
         run_len  <= 0;
      end else begin
         prev_sel <= bus.spi_select;
         if (bus.spi_select) begin
            if (!prev_sel) begin
               cur    <= '{addr: bus.spi_mem_addr, data: bus.spi_data_from_cpu, wr: !bus.spi_write_n};
               cur_wn <= bus.spi_write_n;
               cur_rn <= bus.spi_read_n;
               run_len <= 1;
               if (bus.spi_write_n == bus.spi_read_n) viol <= viol + 1;
            end else begin
               run_len <= run_len + 1;
               if (bus.spi_mem_addr != cur.addr || bus.spi_data_from_cpu != cur.data ||
                   bus.spi_write_n != cur_wn || bus.spi_read_n != cur_rn)
                  viol <= viol + 1;
            end
         end else if (prev_sel) begin
            if (run_len != 2) viol <= viol + 1;
            obs_q.push_back(cur);
         end
      end
   end

   // ---------------- scoreboard helpers ----------------
   logic [15:0] tx_words[16];
   logic [15:0] rx_q[$];
   logic [15:0] exp_rx_q[$];

   task automatic push_acc(input logic [2:0] addr, input logic [15:0] data, input logic wr);
      exp_q.push_back('{addr: addr, data: data, wr: wr});
   endtask

   task automatic push_burst(input int len, input bit timeout_first);
      push_acc(3'd2, 16'h0000, 1'b1);
      push_acc(3'd5, SLAVE_MASK, 1'b1);
      push_acc(3'd3, 16'h0400, 1'b1);
      for (int i = 0; i < len; i++) begin
         push_acc(3'd1, tx_words[i], 1'b1);
         if (timeout_first) break;
         push_acc(3'd0, 16'h0000, 1'b0);
         exp_rx_q.push_back(tx_words[i]);
      end
      push_acc(3'd3, 16'h0000, 1'b1);
   endtask

   // number of differences between queued and observed accesses since base
   function automatic int trace_mismatches(input int base);
      int n = 0;
      if (obs_q.size() - base != exp_q.size()) n++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         if (obs_q[base+i].addr != exp_q[i].addr || obs_q[base+i].wr != exp_q[i].wr ||
             (exp_q[i].wr && obs_q[base+i].data != exp_q[i].data))
            n++;
      end
      exp_q.delete();
      return n;
   endfunction

   function automatic int rx_mismatches();
      int n = 0;
      if (rx_q.size() != exp_rx_q.size()) n++;
      for (int i = 0; i < exp_rx_q.size() && i < rx_q.size(); i++)
         if (rx_q[i] !== exp_rx_q[i]) n++;
      exp_rx_q.delete();
      return n;
   endfunction

   // ---------------- burst driver ----------------
   int r_done_cnt, r_done_cyc, r_tx_cyc, r_done_run_max;
   bit r_timeout, r_err_first, r_pulse_seen, r_cmd_ready_pulse, r_aborted, r_sso_low_at_rx;

   task automatic do_burst(input int len, input int rx_delay, input int pulse_at, input int abort_rx);
      int tx_idx = 0;
      int rx_wait = 0;
      int cyc = 0;
      int run = 0;
      bit fin = 1'b0;
      r_done_cnt = 0; r_done_cyc = 0; r_tx_cyc = 0; r_done_run_max = 0;
      r_timeout = 1'b0; r_err_first = 1'b0; r_pulse_seen = 1'b0;
      r_cmd_ready_pulse = 1'b0; r_aborted = 1'b0; r_sso_low_at_rx = 1'b0;
      rx_q.delete();
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LEN_W'(len);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      while (!fin) begin
         bus.tx_valid  = (tx_idx < len);
         bus.tx_data   = tx_words[tx_idx % 16];
         bus.rx_ready  = (rx_wait >= rx_delay);
         bus.cmd_valid = (cyc == pulse_at);
         bus.cmd_len   = LEN_W'(5);
         #1;
         if (cyc == 0) r_err_first = bus.error;
         if (bus.cmd_valid) begin
            r_pulse_seen      = 1'b1;
            r_cmd_ready_pulse = bus.cmd_ready;
         end
         if (bus.tx_valid && bus.tx_ready) begin
            tx_idx++;
            r_tx_cyc = cyc;
         end
         if (bus.rx_valid) begin
            if (bus.rx_ready) begin
               rx_q.push_back(bus.rx_data);
               if (!m_sso) r_sso_low_at_rx = 1'b1;
               rx_wait = 0;
            end else begin
               rx_wait++;
            end
         end
         if (bus.done) begin
            r_done_cnt++;
            r_done_cyc = cyc;
            run++;
            if (run > r_done_run_max) r_done_run_max = run;
         end else begin
            run = 0;
         end
         if (abort_rx >= 0 && rx_q.size() == abort_rx && tx_idx == abort_rx + 1) begin
            r_aborted = 1'b1;
            fin = 1'b1;
         end else if (r_done_cnt > 0 && cyc >= r_done_cyc + 3) begin
            fin = 1'b1;
         end else if (cyc >= BUDGET) begin
            r_timeout = 1'b1;
            fin = 1'b1;
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.tx_valid  = 1'b0;
      bus.rx_ready  = 1'b0;
      bus.cmd_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.cmd_ready, bus.busy, bus.done, bus.error, bus.rx_valid, bus.tx_ready,
           bus.spi_select, bus.spi_write_n, bus.spi_read_n} !== 9'b100000011) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 100000011",
                  {bus.cmd_ready, bus.busy, bus.done, bus.error, bus.rx_valid, bus.tx_ready,
                   bus.spi_select, bus.spi_write_n, bus.spi_read_n});
      end
      checks++;
      if (bus.rx_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rx_data: got %h expected 0000", bus.rx_data);
      end
      checks++;
      if ({bus.spi_mem_addr, bus.spi_data_from_cpu} !== 19'h0) begin
         errors++;
         $display("FAIL reset_bus: got addr %0d data %h expected 0/0000",
                  bus.spi_mem_addr, bus.spi_data_from_cpu);
      end
   endtask

   task automatic test_single_word();
      int base = obs_q.size();
      int v0 = viol;
      tx_words[0] = 16'hA5C3;
      push_burst(1, 1'b0);
      do_burst(1, 0, -1, -1);
      checks++;
      if (r_timeout) begin errors++; $display("FAIL single_timeout: no done within %0d cycles", BUDGET); end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 16'hA5C3) begin
         errors++;
         $display("FAIL single_rx: got %0d words first %h expected 1 word A5C3",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx);
      end
      void'(rx_mismatches());
      checks++;
      if (trace_mismatches(base) != 0) begin errors++; $display("FAIL single_trace: bus access sequence differs from expected"); end
      checks++;
      if (r_done_cnt != 1 || r_done_run_max != 1) begin
         errors++;
         $display("FAIL single_done: got %0d pulses width %0d expected 1 width 1", r_done_cnt, r_done_run_max);
      end
      checks++;
      if (viol != v0) begin errors++; $display("FAIL single_protocol: got %0d violations expected 0", viol - v0); end
   endtask

   task automatic test_multi_word();
      int base = obs_q.size();
      int f0 = sso_falls;
      tx_words[0] = 16'h0001; tx_words[1] = 16'h8000; tx_words[2] = 16'hFFFF;
      push_burst(3, 1'b0);
      do_burst(3, 20, -1, -1);
      checks++;
      if (rx_mismatches() != 0) begin errors++; $display("FAIL multi_rx: got %0d words expected 3 in order", rx_q.size()); end
      checks++;
      if (trace_mismatches(base) != 0) begin errors++; $display("FAIL multi_trace: bus access sequence differs from expected"); end
      checks++;
      if (sso_falls - f0 != 1 || r_sso_low_at_rx) begin
         errors++;
         $display("FAIL multi_ss_n: got %0d SS_n releases (low at rx %0d) expected 1 (0)", sso_falls - f0, r_sso_low_at_rx);
      end
      checks++;
      if ({m_roe, m_toe} !== 2'b00) begin errors++; $display("FAIL multi_roe_toe: got %b expected 00", {m_roe, m_toe}); end
      checks++;
      if (r_done_cnt != 1) begin errors++; $display("FAIL multi_done: got %0d pulses expected 1", r_done_cnt); end
   endtask

   task automatic test_zero_len();
      int base = obs_q.size();
      do_burst(0, 0, -1, -1);
      checks++;
      if (r_done_cnt != 1 || r_done_cyc > 1) begin
         errors++;
         $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at <=1", r_done_cnt, r_done_cyc);
      end
      checks++;
      if (obs_q.size() != base) begin errors++; $display("FAIL zero_bus: got %0d accesses expected 0", obs_q.size() - base); end
   endtask

   task automatic test_timeout();
      int base = obs_q.size();
      int gap;
      stuck = 1'b1;
      tx_words[0] = 16'hDEAD;
      push_burst(1, 1'b1);
      do_burst(1, 0, -1, -1);
      gap = r_done_cyc - r_tx_cyc;
      checks++;
      if (bus.error !== 1'b1 || r_done_cnt != 1) begin
         errors++;
         $display("FAIL timeout_error: got error %b done %0d expected 1/1", bus.error, r_done_cnt);
      end
      checks++;
      if (gap < RX_TIMEOUT || gap > RX_TIMEOUT + 16) begin
         errors++;
         $display("FAIL timeout_wait: got %0d cycles expected %0d..%0d", gap, RX_TIMEOUT, RX_TIMEOUT + 16);
      end
      checks++;
      if (trace_mismatches(base) != 0 || rx_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_trace: bus sequence or rx count (%0d) differs from expected", rx_q.size());
      end
      stuck = 1'b0;
      base = obs_q.size();
      tx_words[0] = 16'h1234;
      push_burst(1, 1'b0);
      do_burst(1, 0, -1, -1);
      checks++;
      if (r_err_first !== 1'b0 || bus.error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got error %b after accept %b at end expected 0/0", r_err_first, bus.error);
      end
      checks++;
      if (rx_mismatches() != 0 || trace_mismatches(base) != 0) begin
         errors++;
         $display("FAIL timeout_recover: got %0d rx words expected 1 word 1234 with full trace", rx_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int base;
      tx_words[0] = 16'h1111; tx_words[1] = 16'h2222; tx_words[2] = 16'h3333;
      do_burst(3, 0, -1, 1);
      exp_q.delete();
      exp_rx_q.delete();
      checks++;
      if (!r_aborted || r_done_cnt != 0) begin
         errors++;
         $display("FAIL midreset_reach: got aborted %b done %0d expected 1/0", r_aborted, r_done_cnt);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.cmd_ready, bus.busy, bus.done, bus.error, bus.rx_valid, bus.tx_ready,
           bus.spi_select, bus.spi_write_n, bus.spi_read_n, m_sso} !== 10'b1000000110) begin
         errors++;
         $display("FAIL midreset_outputs: got %b expected 1000000110 (last bit SSO)",
                  {bus.cmd_ready, bus.busy, bus.done, bus.error, bus.rx_valid, bus.tx_ready,
                   bus.spi_select, bus.spi_write_n, bus.spi_read_n, m_sso});
      end
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got done %b busy %b expected 0/0", bus.done, bus.busy);
         end
      end
      base = obs_q.size();
      tx_words[0] = 16'h5A5A;
      push_burst(1, 1'b0);
      do_burst(1, 0, -1, -1);
      checks++;
      if (rx_mismatches() != 0 || trace_mismatches(base) != 0 || r_done_cnt != 1) begin
         errors++;
         $display("FAIL midreset_recover: got %0d rx words %0d done expected 1 word 5A5A, 1 done", rx_q.size(), r_done_cnt);
      end
   endtask

   task automatic test_busy_cmd();
      int base = obs_q.size();
      tx_words[0] = 16'h0F0F; tx_words[1] = 16'hF0F0;
      push_burst(2, 1'b0);
      do_burst(2, 0, 5, -1);
      checks++;
      if (!r_pulse_seen || r_cmd_ready_pulse !== 1'b0) begin
         errors++;
         $display("FAIL busy_cmd_ready: got seen %b cmd_ready %b expected 1/0", r_pulse_seen, r_cmd_ready_pulse);
      end
      checks++;
      if (rx_mismatches() != 0 || trace_mismatches(base) != 0) begin
         errors++;
         $display("FAIL busy_count: got %0d rx words expected 2 with 2-word trace", rx_q.size());
      end
      checks++;
      if (r_done_cnt != 1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_dropped: got done %0d busy %b expected 1/0", r_done_cnt, bus.busy);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.rx_ready  = 1'b0;
      test_reset();
      test_single_word();
      test_multi_word();
      test_zero_len();
      test_timeout();
      test_reset_mid();
      test_busy_cmd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
